// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. One digit is lit per
// slot of CLK_DIV cycles; each slot opens with BLANK_CYCLES of all anodes off.
// New values are staged in a pending register and move to the active
// register only on a frame boundary. All display outputs are registered.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    in_blank;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    zero_run;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // A zero-length blank window must not synthesise an always-false compare.
  if (BLANK_CYCLES > 0) begin : g_blank
    assign in_blank = (cnt_q < BLANK_LIM);
  end else begin : g_noblank
    assign in_blank = 1'b0;
  end

  // Leading-zero mask (scan from the top digit down) and selection of the current digit.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run && (act_data_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      lz_blank[NUM_DIGITS-1-j] = zero_run && blank_lz;
    end
    lz_blank[0] = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = act_data_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
        cur_lz  = lz_blank[i];
      end
    end
  end

  // Next-state: slot counter, digit index, pending/active staging, display outputs.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    seg_d        = '1;
    dp_d         = 1'b1;
    an_d         = '1;
    fs_d         = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (idx_q == IDX_LAST) begin
        fs_d = 1'b1;
        if (pend_valid_q) begin
          act_data_d   = pend_data_q;
          act_dp_d     = pend_dp_q;
          pend_valid_d = 1'b0;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Load is applied after the boundary transfer so a boundary-cycle load
    // stays pending for one more frame.
    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    if (!in_blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = cur_lz ? 7'h7F : ~decode(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fs_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 4-digit instance and a 1-digit instance
// share one stimulus stream and are both compared every cycle against a
// time-indexed reference model.
module tb_seven_seg_scan_driver;

  localparam int N0 = 4, D0 = 4, B0 = 1;
  localparam int N1 = 1, D1 = 3, B1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;
  logic [3:0] an0;
  logic [0:0] an1;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N0), .CLK_DIV(D0), .BLANK_CYCLES(B0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(N1), .CLK_DIV(D1), .BLANK_CYCLES(B1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data[3:0]), .dp_in(dp_in[0:0]), .load(load),
    .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1)
  );

  int checks = 0;
  int fails  = 0;

  // Segments lit (a..g) per hex value.
  logic [6:0] lit_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: k = number of clock edges since reset release.
  int unsigned k;
  logic [15:0] act_m [2];
  logic [15:0] pend_m [2];
  logic [3:0]  adp_m [2];
  logic [3:0]  pdp_m [2];
  logic        pv_m [2];
  logic [6:0]  exp_seg [2];
  logic [3:0]  exp_an [2];
  logic        exp_dp [2];
  logic        exp_fs [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int u = 0; u < 2; u++) begin
      act_m[u] = '0; pend_m[u] = '0; adp_m[u] = '0; pdp_m[u] = '0; pv_m[u] = 1'b0;
    end
  endtask

  // Predict outputs after this edge from the pre-edge position and active value, then stage loads.
  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      int n, dv, bk, c, dig, frame;
      logic [15:0] upper;
      n     = (u == 0) ? N0 : N1;
      dv    = (u == 0) ? D0 : D1;
      bk    = (u == 0) ? B0 : B1;
      c     = int'(k % dv);
      dig   = int'((k / dv) % n);
      frame = dv * n;
      upper = act_m[u] >> (4 * dig);
      if (c < bk) begin
        exp_an[u]  = 4'((1 << n) - 1);
        exp_seg[u] = 7'h7F;
        exp_dp[u]  = 1'b1;
      end else begin
        exp_an[u]  = 4'(~(1 << dig) & ((1 << n) - 1));
        exp_seg[u] = (blank_lz && dig != 0 && upper == 0) ? 7'h7F : ~lit_tbl[upper[3:0]];
        exp_dp[u]  = ~adp_m[u][dig];
      end
      exp_fs[u] = ((k % frame) == frame - 1);
      if (exp_fs[u] && pv_m[u]) begin
        act_m[u] = pend_m[u]; adp_m[u] = pdp_m[u]; pv_m[u] = 1'b0;
      end
      if (load) begin
        pend_m[u] = (u == 0) ? data : {12'b0, data[3:0]};
        pdp_m[u]  = (u == 0) ? dp_in : {3'b0, dp_in[0]};
        pv_m[u]   = 1'b1;
      end
    end
    k++;
  endtask

  task automatic compare_all();
    check("an4",  an0,  exp_an[0]);
    check("seg4", seg0, exp_seg[0]);
    check("dp4",  dp0,  exp_dp[0]);
    check("fs4",  fs0,  exp_fs[0]);
    check("an1",  an1,  exp_an[1]);
    check("seg1", seg1, exp_seg[1]);
    check("dp1",  dp1,  exp_dp[1]);
    check("fs1",  fs1,  exp_fs[1]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg4"}, seg0, 7'h7F);
    check({tag, "_an4"},  an0,  4'hF);
    check({tag, "_dp4"},  dp0,  1'b1);
    check({tag, "_fs4"},  fs0,  1'b0);
    check({tag, "_seg1"}, seg1, 7'h7F);
    check({tag, "_an1"},  an1,  1'b1);
    check({tag, "_dp1"},  dp1,  1'b1);
    check({tag, "_fs1"},  fs1,  1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge is frame position p of the 4-digit instance.
  task automatic wait_pos(input int p);
    for (int i = 0; i < 32 && int'(k % (N0 * D0)) != p; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    check_reset({tag, "_held"});
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset("rst0");

    // Plain scanning of zero, frame pulses.
    run(40);

    // Mid-frame load, visible only after the next boundary.
    wait_pos(5);
    do_load(16'h12AF, 4'b0100);
    run(40);
    wait_pos(2);  check("h12af_d0_seg", seg0, 7'b0111000); check("h12af_d0_an", an0, 4'b1110);
    wait_pos(6);  check("h12af_d1_seg", seg0, 7'b0001000); check("h12af_d1_an", an0, 4'b1101);
    wait_pos(10); check("h12af_d2_seg", seg0, 7'b0010010); check("h12af_d2_dp", dp0, 1'b0);
    wait_pos(14); check("h12af_d3_seg", seg0, 7'b1001111); check("h12af_d3_dp", dp0, 1'b1);

    // Two loads in one frame: last wins.
    wait_pos(3);  do_load(16'h1111, 4'b0000);
    wait_pos(8);  do_load(16'h2222, 4'b0000);
    run(20);
    // Load on the boundary edge itself stays pending one more frame.
    wait_pos(15); do_load(16'h3333, 4'b0001);
    run(20);
    // Pending 4444, then boundary-cycle load 5555: 4444 goes active first.
    wait_pos(4);  do_load(16'h4444, 4'b0000);
    wait_pos(15); do_load(16'h5555, 4'b1000);
    run(40);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    wait_pos(6);  do_load(16'h0050, 4'b0000);
    run(30);
    wait_pos(14); check("lz_d3_seg", seg0, 7'h7F); check("lz_d3_an", an0, 4'b0111);
    wait_pos(10); check("lz_d2_seg", seg0, 7'h7F); check("lz_d2_an", an0, 4'b1011);
    wait_pos(6);  check("lz_d1_seg", seg0, 7'b0100100);
    wait_pos(2);  check("lz_d0_seg", seg0, 7'b0000001);
    do_load(16'h0000, 4'b0010);
    run(40);
    blank_lz = 1'b0;
    run(8);

    // Reset while digit 2 is lit.
    wait_pos(10);
    check("pre_rst_an", an0, 4'b1011);
    apply_reset("rst_mid");
    run(24);

    // Randomized loads and live blank_lz changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) begin
        data = 16'($urandom);
        if ($urandom_range(2) == 0) data = data & 16'h00FF;
        dp_in = 4'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(19) == 0) blank_lz = ~blank_lz;
      step();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
